// File: rtl/sync_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module      : sync_frame_serializer
// Description : Serializes a handshaked payload word into a frame of SYNC
//               preamble, payload (MSB first), optional parity, and zero gap.
//               Optional even parity bit: define SYNC_FRAME_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_frame_serializer #(
    parameter int                DATA_W     = 8,
    parameter int                SYNC_W     = 5,
    parameter logic [SYNC_W-1:0] SYNC_PAT   = 5'b11010,
    parameter int                GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              stream_out,
    output logic              busy,
    output logic              frame_done
);
    localparam int c_MAX_W = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int c_CNT_W = $clog2(c_MAX_W + 1);
    localparam int c_GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

    localparam logic [c_CNT_W-1:0] c_SYNC_LAST   = c_CNT_W'(SYNC_W - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST   = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_PENULT = c_CNT_W'(DATA_W - 2);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST    = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef SYNC_FRAME_PARITY_EN
    localparam bit c_PAR_EN = 1'b1;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_PAR  = 3'd3,
        ST_GAP  = 3'd4
    } state_t;
    logic r_par;
`else
    localparam bit c_PAR_EN = 1'b0;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_GAP  = 3'd4
    } state_t;
`endif

    state_t              r_state;
    logic [DATA_W-1:0]   r_shreg;
    logic [SYNC_W-1:0]   r_sync_sh;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_GAP_W-1:0]  r_gap_cnt;

    assign in_ready = (r_state == ST_IDLE) && rst;

    // Outputs are registered against the next state, so the bit on stream_out
    // always belongs to the current r_state and r_cnt position.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_sync_sh  <= '0;
            r_cnt      <= '0;
            r_gap_cnt  <= '0;
            stream_out <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef SYNC_FRAME_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    stream_out <= 1'b0;
                    busy       <= 1'b0;
                    if (in_valid) begin
                        r_state    <= ST_SYNC;
                        r_cnt      <= '0;
                        r_shreg    <= in_data;
                        r_sync_sh  <= SYNC_PAT << 1;
                        stream_out <= SYNC_PAT[SYNC_W-1];
                        busy       <= 1'b1;
`ifdef SYNC_FRAME_PARITY_EN
                        r_par      <= ^in_data;
`endif
                    end
                end
                ST_SYNC: begin
                    if (r_cnt == c_SYNC_LAST) begin
                        r_state    <= ST_DATA;
                        r_cnt      <= '0;
                        stream_out <= r_shreg[DATA_W-1];
                        r_shreg    <= r_shreg << 1;
                        frame_done <= (DATA_W == 1) && !c_PAR_EN;
                    end else begin
                        r_cnt      <= r_cnt + 1'b1;
                        stream_out <= r_sync_sh[SYNC_W-1];
                        r_sync_sh  <= r_sync_sh << 1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == c_DATA_LAST) begin
                        r_cnt <= '0;
`ifdef SYNC_FRAME_PARITY_EN
                        r_state    <= ST_PAR;
                        stream_out <= r_par;
                        frame_done <= 1'b1;
`else
                        stream_out <= 1'b0;
                        r_gap_cnt  <= '0;
                        if (GAP_CYCLES > 0) begin
                            r_state <= ST_GAP;
                        end else begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end
`endif
                    end else begin
                        r_cnt      <= r_cnt + 1'b1;
                        stream_out <= r_shreg[DATA_W-1];
                        r_shreg    <= r_shreg << 1;
                        frame_done <= (r_cnt == c_DATA_PENULT) && !c_PAR_EN;
                    end
                end
`ifdef SYNC_FRAME_PARITY_EN
                ST_PAR: begin
                    r_cnt      <= '0;
                    stream_out <= 1'b0;
                    r_gap_cnt  <= '0;
                    if (GAP_CYCLES > 0) begin
                        r_state <= ST_GAP;
                    end else begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
`endif
                ST_GAP: begin
                    stream_out <= 1'b0;
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    stream_out <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_frame_serializer
// Description : Scoreboard testbench for sync_frame_serializer with a
//               behavioural SYNC detector on the loopback path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_frame_serializer;
    localparam int SW  = 5;
    localparam int DW  = 8;
    localparam int GAP = 2;
`ifdef SYNC_FRAME_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL = SW + DW + P + GAP;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          stream_out;
    logic          busy;
    logic          frame_done;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {logic s; logic fd; logic bz;} exp_t;
    exp_t q[$];
    logic [SW-1:0] sync_pat = 5'b11010;

    logic          det_rst_n = 1'b0;
    logic [SW-1:0] det_hist;
    logic          pattern_found;

    sync_frame_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .stream_out (stream_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Receiver-side pattern detector model fed by the serial stream.
    always @(posedge clk) begin
        if (!det_rst_n) begin
            det_hist      <= '0;
            pattern_found <= 1'b0;
        end else begin
            det_hist      <= {det_hist[SW-2:0], stream_out};
            pattern_found <= ({det_hist[SW-2:0], stream_out} == sync_pat);
        end
    end

    task automatic push_frame(input logic [DW-1:0] d);
        for (int i = SW - 1; i >= 0; i--) q.push_back('{s: sync_pat[i], fd: 1'b0, bz: 1'b1});
        for (int i = DW - 1; i >= 0; i--) q.push_back('{s: d[i], fd: (i == 0) && (P == 0), bz: 1'b1});
        if (P == 1) q.push_back('{s: ^d, fd: 1'b1, bz: 1'b1});
        for (int i = 0; i < GAP; i++) q.push_back('{s: 1'b0, fd: 1'b0, bz: 1'b1});
    endtask

    task automatic push_idle();
        q.push_back('{s: 1'b0, fd: 1'b0, bz: 1'b0});
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({stream_out, frame_done, busy} !== 3'b000) begin
            failures++; $display("FAIL reset_outputs actual=%b required=000", {stream_out, frame_done, busy});
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_in_ready actual=%b required=0", in_ready);
        end
        in_valid = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_release_ready actual=%b required=1", in_ready);
        end
    endtask

    task automatic test_single_frame();
        exp_t e;
        int k = 0;
        logic [14:0] seq = '0;
        in_valid = 1'b1; in_data = 8'hA5;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL single_ready_pre actual=%b required=1", in_ready);
        end
        push_frame(8'hA5);
        while (q.size() > 0) begin
            @(posedge clk); #1; k++;
            if (k == 1) in_valid = 1'b0;
            e = q.pop_front();
            seq = {seq[13:0], stream_out};
            checks++;
            if ({stream_out, frame_done, busy} !== e) begin
                failures++; $display("FAIL single cycle=%0d actual(s,fd,bz)=%b required=%b", k, {stream_out, frame_done, busy}, e);
            end
        end
`ifndef SYNC_FRAME_PARITY_EN
        checks++;
        if (seq !== 15'b110101010010100) begin
            failures++; $display("FAIL single_sequence actual=%b required=110101010010100", seq);
        end
`endif
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL single_ready_after actual=%b%b required=10", in_ready, busy);
        end
    endtask

`ifdef SYNC_FRAME_PARITY_EN
    task automatic test_parity();
        logic [DW-1:0] words [2] = '{8'hA5, 8'h01};
        logic          pbits [2] = '{1'b0, 1'b1};
        exp_t e;
        for (int w = 0; w < 2; w++) begin
            int k = 0;
            in_valid = 1'b1; in_data = words[w];
            push_frame(words[w]);
            while (q.size() > 0) begin
                @(posedge clk); #1; k++;
                if (k == 1) in_valid = 1'b0;
                e = q.pop_front();
                checks++;
                if ({stream_out, frame_done, busy} !== e) begin
                    failures++; $display("FAIL parity w=%0d cycle=%0d actual=%b required=%b", w, k, {stream_out, frame_done, busy}, e);
                end
                if (k == SW + DW + 1) begin
                    checks++;
                    if (stream_out !== pbits[w] || frame_done !== 1'b1) begin
                        failures++; $display("FAIL parity_bit w=%0d actual=%b%b required=%b1", w, stream_out, frame_done, pbits[w]);
                    end
                end
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    task automatic test_back_to_back();
        exp_t e;
        int k = 0;
        in_valid = 1'b1; in_data = 8'h0F;
        push_frame(8'h0F);
        push_idle();
        push_frame(8'hF0);
        while (q.size() > 0) begin
            @(posedge clk); #1; k++;
            if (k == 1) in_data = 8'hF0;
            if (k == FL + 1) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++; $display("FAIL b2b_ready actual=%b required=1", in_ready);
                end
            end
            if (k == FL + 2) in_valid = 1'b0;
            e = q.pop_front();
            checks++;
            if ({stream_out, frame_done, busy} !== e) begin
                failures++; $display("FAIL b2b cycle=%0d actual(s,fd,bz)=%b required=%b", k, {stream_out, frame_done, busy}, e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_busy();
        exp_t e;
        int k = 0;
        in_valid = 1'b1; in_data = 8'h3C;
        push_frame(8'h3C);
        while (q.size() > 0) begin
            @(posedge clk); #1; k++;
            if (k == 1) in_valid = 1'b0;
            if (k == SW + 2) begin
                in_valid = 1'b1; in_data = 8'hFF;
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++; $display("FAIL busy_ready actual=%b required=0", in_ready);
                end
            end
            if (k == SW + 4) in_valid = 1'b0;
            e = q.pop_front();
            checks++;
            if ({stream_out, frame_done, busy} !== e) begin
                failures++; $display("FAIL ignore_busy cycle=%0d actual(s,fd,bz)=%b required=%b", k, {stream_out, frame_done, busy}, e);
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({stream_out, busy, in_ready} !== 3'b001) begin
            failures++; $display("FAIL ignore_busy_after actual=%b required=001", {stream_out, busy, in_ready});
        end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        int k = 0;
        in_valid = 1'b1; in_data = 8'hA5;
        push_frame(8'hA5);
        while (q.size() > SW + 3) void'(q.pop_back());
        while (q.size() > 0) begin
            @(posedge clk); #1; k++;
            if (k == 1) in_valid = 1'b0;
            e = q.pop_front();
            checks++;
            if ({stream_out, frame_done, busy} !== e) begin
                failures++; $display("FAIL midrst_pre cycle=%0d actual=%b required=%b", k, {stream_out, frame_done, busy}, e);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({stream_out, frame_done, busy, in_ready} !== 4'b0000) begin
            failures++; $display("FAIL midrst_outputs actual=%b required=0000", {stream_out, frame_done, busy, in_ready});
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL midrst_ready actual=%b required=1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({stream_out, frame_done, busy} !== 3'b000) begin
                failures++; $display("FAIL midrst_residual i=%0d actual=%b required=000", i, {stream_out, frame_done, busy});
            end
        end
        k = 0;
        in_valid = 1'b1; in_data = 8'h5A;
        push_frame(8'h5A);
        while (q.size() > 0) begin
            @(posedge clk); #1; k++;
            if (k == 1) in_valid = 1'b0;
            e = q.pop_front();
            checks++;
            if ({stream_out, frame_done, busy} !== e) begin
                failures++; $display("FAIL midrst_next cycle=%0d actual=%b required=%b", k, {stream_out, frame_done, busy}, e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_loopback();
        exp_t e;
        logic pf_exp;
        int k = 0;
        int pulses = 0;
        det_rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h00;
        for (int f = 0; f < 3; f++) begin
            push_frame(8'h00);
            if (f < 2) push_idle();
        end
        while (q.size() > 0) begin
            @(posedge clk); #1; k++;
            if (k == 2 * (FL + 1) + 1) in_valid = 1'b0;
            e = q.pop_front();
            pf_exp = (k >= SW + 1) && (((k - (SW + 1)) % (FL + 1)) == 0);
            if (pattern_found === 1'b1) pulses++;
            checks++;
            if ({stream_out, frame_done, busy, pattern_found} !== {e, pf_exp}) begin
                failures++; $display("FAIL loopback cycle=%0d actual(s,fd,bz,pf)=%b required=%b", k, {stream_out, frame_done, busy, pattern_found}, {e, pf_exp});
            end
        end
        checks++;
        if (pulses !== 3) begin
            failures++; $display("FAIL loopback_pulses actual=%0d required=3", pulses);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
`ifdef SYNC_FRAME_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_ignore_busy();
        test_reset_midframe();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_frame_serializer.md
Name: sync_frame_serializer

Overview:
- Transmit-side counterpart of the serial pattern detector.
- Accepts a parallel payload word over a valid/ready handshake and emits it on a one-bit serial stream as a frame: SYNC preamble (default 11010), payload MSB-first, optional parity bit, then a fixed idle gap of zeros.
- Drives stimulus or link traffic into the detector's stream_in; the detector flags each preamble.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- SYNC_W, 5, preamble length in bits (>=1).
- SYNC_PAT, 5'b11010, preamble value, sent MSB first.
- GAP_CYCLES, 2, idle zero cycles after each frame before in_ready re-asserts (>=0).

Ports:
- clk  input  1  single rising-edge clock.
- rst  input  1  reset; synchronous, active-low (0 = reset, sampled on rising clk).
- in_valid  input  1  payload word available.
- in_data  input  DATA_W  payload word; sampled only on handshake.
- in_ready  output  1  block can accept a word this cycle.
- stream_out  output  1  serial bit stream, registered.
- busy  output  1  frame in progress (SYNC/DATA/PAR/GAP states).
- frame_done  output  1  one-cycle pulse coincident with the last frame bit on stream_out.

Behaviour:
- State machine and per-state behaviour:
  - IDLE:
    - stream_out=0.
    - in_ready=1.
  - SYNC:
    - Outputs SYNC_PAT bits MSB to LSB, one per cycle, SYNC_W cycles.
  - DATA:
    - Outputs the latched payload MSB to LSB, DATA_W cycles.
  - PAR:
    - Present only with the macro; 1 cycle.
  - GAP:
    - stream_out=0 for GAP_CYCLES cycles.
    - Skipped when GAP_CYCLES=0.
  - After GAP (or the last bit when GAP_CYCLES=0), return to IDLE.
- Handshake:
  - Transfer occurs on a rising edge where in_valid=1, in_ready=1 and rst=1.
  - in_data is latched into an internal shift register.
  - The state moves to SYNC at that same edge.
  - First preamble bit appears on stream_out in the cycle immediately after the accepting edge (latency 1).
- in_ready:
  - in_ready = (state==IDLE) && rst.
  - It is 0 in all other states, so in_valid outside IDLE is ignored and in_data may change freely.
- Bit counter width is clog2(max(SYNC_W, DATA_W)+1); it resets to 0 on every state entry.
- frame_done:
  - High exactly during the cycle the final frame bit is driven: last payload bit without parity, parity bit with parity.
  - Never high in GAP or IDLE.
- busy=1 from the cycle after acceptance through the last GAP cycle inclusive.
- Back-to-back frames:
  - If in_valid is held high, the next word is accepted on the first IDLE cycle.
  - Frame period = SYNC_W + DATA_W + P + GAP_CYCLES + 1 cycles (P=1 with parity, else 0).
- Reset:
  - Every rising edge with rst=0 forces state=IDLE, shift register=0 and counter=0.
  - Registered outputs after that edge: stream_out=0, busy=0, frame_done=0.
  - in_ready=0 while rst=0.
- Reset mid-frame aborts immediately: the partial frame is discarded, no frame_done pulse is issued, and no residual bits are sent after reset deasserts.
- Payload content is not scrambled. A payload containing SYNC_PAT will also match at a receiver; this is permitted and is the sender's responsibility.

Optional Feature:
- Macro: SYNC_FRAME_PARITY_EN.
- Defined:
  - PAR state is compiled in.
  - One even-parity bit (XOR of all DATA_W payload bits) is sent after the payload LSB.
  - frame_done moves to the parity cycle.
- Undefined:
  - No PAR state and no parity logic.
  - Frame = SYNC + DATA + GAP.

Test Plan:
- Single frame, defaults, no macro: after reset release, drive in_valid=1, in_data=8'hA5 for one accepted edge.
  - Required stream_out from the next cycle: 1,1,0,1,0, 1,0,1,0,0,1,0,1, then 0,0.
  - frame_done=1 only on the 13th bit.
  - in_ready=1 again in cycle 16.
- Parity (SYNC_FRAME_PARITY_EN defined):
  - in_data=8'hA5 -> parity bit 0 on cycle 14, with frame_done there.
  - in_data=8'h01 -> parity bit 1.
- Back-to-back: hold in_valid=1 with words 8'h0F then 8'hF0.
  - Second preamble starts exactly 16 cycles after the first (no parity).
  - No extra idle beyond GAP_CYCLES+1.
- Ignore while busy: pulse in_valid with 8'hFF during DATA of a frame carrying 8'h3C.
  - Transmitted payload remains 0,0,1,1,1,1,0,0.
  - 8'hFF is never sent.
- Reset mid-frame: assert rst=0 for one edge during the 3rd payload bit.
  - stream_out=0, busy=0, frame_done=0 after that edge.
  - in_ready=1 the cycle after rst=1.
  - The next frame is complete and correct.
- Loopback: connect stream_out to the pattern detector (same clk, detector reset held inactive after init) and send payload 8'h00 three times.
  - The detector's pattern_found pulses exactly once per frame, the cycle after the 5th preamble bit.
